// File: rtl/alu_dispatch.sv
// alu_dispatch: dispatches one decoded RV32IM integer instruction (OP, OP-IMM,
// LUI, AUIPC) to an external registered ALU and returns the result to
// writeback.
//
// Flow: IDLE accepts an instruction and registers the ALU opcode and operands.
// EXEC waits ALU_LAT cycles and then captures alu_out. RESP holds the result
// until writeback takes it. Only one instruction is in flight, so the
// throughput is one instruction per ALU_LAT+2 cycles.
//
// ALU timing contract:
//   alu_op/alu_in1/alu_in2 are loaded on the accept edge. These registers are
//   the ALU's first stage, so alu_out must be valid ALU_LAT-1 edges after the
//   accept edge. alu_out is sampled on the edge that ends the last EXEC cycle.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   in_valid/in_ready            instruction handshake
//   in_opcode/funct3/funct7      instruction encoding fields
//   in_rs1/in_rs2/in_imm/in_pc   source values, immediate, PC
//   in_rd                        destination register
//   alu_op/alu_in1/alu_in2       registered ALU opcode and operands
//   alu_out                      ALU result
//   wb_valid/wb_ready            result handshake
//   wb_rd/wb_data/wb_illegal     result record; wb_data is 0 when illegal
//
// Optional build macro ALU_DISPATCH_FWD_EN:
//   Adds in_rs1_idx/in_rs2_idx. On accept, an operand whose index matches the
//   last delivered, legal, rd!=0 result takes that result instead of the
//   regfile value.
module alu_dispatch #(
  parameter int ALU_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
`ifdef ALU_DISPATCH_FWD_EN
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
`endif
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam int         CNT_W     = 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [4:0]        alu_op_reg, rd_reg, wb_rd_reg;
  logic [XLEN-1:0]   alu_in1_reg, alu_in2_reg, wb_data_reg;
  logic              ill_reg, wb_illegal_reg;

  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic [4:0]        dec_op;
  logic [XLEN-1:0]   dec_in1, dec_in2;
  logic              dec_illegal;
  logic              is_shift;
  logic              accept, capture;

  assign accept  = (state_reg == S_IDLE) && in_valid;
  assign capture = (state_reg == S_EXEC) && (cnt_reg == CNT_W'(1));

  // Base-ISA opcode for funct3. alt selects SUB/SRA (funct7=0100000).
  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? 5'h01 : 5'h00;
      3'b001:  base_op = 5'h02;
      3'b010:  base_op = 5'h08;
      3'b011:  base_op = 5'h09;
      3'b100:  base_op = 5'h03;
      3'b101:  base_op = alt ? 5'h05 : 5'h04;
      3'b110:  base_op = 5'h06;
      default: base_op = 5'h07;
    endcase
  endfunction

`ifdef ALU_DISPATCH_FWD_EN
  // Last result handed to writeback. fwd_ok_reg is set only when that result
  // is forwardable: it was legal and its rd was not x0.
  logic [4:0]      fwd_rd_reg;
  logic [XLEN-1:0] fwd_data_reg;
  logic            fwd_ok_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_rd_reg   <= '0;
      fwd_data_reg <= '0;
      fwd_ok_reg   <= 1'b0;
    end else if (wb_valid && wb_ready) begin
      fwd_rd_reg   <= wb_rd_reg;
      fwd_data_reg <= wb_data_reg;
      fwd_ok_reg   <= !wb_illegal_reg && (wb_rd_reg != 5'd0);
    end
  end

  assign rs1_val = (fwd_ok_reg && in_rs1_idx == fwd_rd_reg) ? fwd_data_reg : in_rs1;
  assign rs2_val = (fwd_ok_reg && in_rs2_idx == fwd_rd_reg) ? fwd_data_reg : in_rs2;
`else
  assign rs1_val = in_rs1;
  assign rs2_val = in_rs2;
`endif

  // Decode: choose the opcode and the operands. Flag unsupported encodings.
  always_comb begin
    dec_op      = OP_ADD;
    dec_in1     = '0;
    dec_in2     = '0;
    dec_illegal = 1'b0;
    is_shift    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    case (in_opcode)
      OPC_OP: begin
        dec_in1 = rs1_val;
        dec_in2 = rs2_val;
        if (in_funct7 == F7_MULDIV) begin
          // M group uses funct3 000..011. The divide half is not supported.
          dec_op      = {3'b100, in_funct3[1:0]};
          dec_illegal = in_funct3[2];
        end else begin
          if (in_funct7 == F7_BASE)
            dec_op = base_op(in_funct3, 1'b0);
          else if (in_funct7 == F7_ALT && (in_funct3 == 3'b000 || in_funct3 == 3'b101))
            dec_op = base_op(in_funct3, 1'b1);
          else
            dec_illegal = 1'b1;
          if (is_shift)
            dec_in2 = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
        end
      end
      OPC_IMM: begin
        dec_in1 = rs1_val;
        dec_in2 = in_imm;
        if (in_funct3 == 3'b001) begin
          dec_op      = base_op(in_funct3, 1'b0);
          dec_illegal = (in_funct7 != F7_BASE);
        end else if (in_funct3 == 3'b101) begin
          dec_op      = base_op(in_funct3, in_funct7 == F7_ALT);
          dec_illegal = (in_funct7 != F7_BASE) && (in_funct7 != F7_ALT);
        end else begin
          // No SUBI exists, so funct7 is ignored for the non-shift forms.
          dec_op = base_op(in_funct3, 1'b0);
        end
        if (is_shift)
          dec_in2 = {{(XLEN-5){1'b0}}, in_imm[4:0]};
      end
      OPC_LUI: begin
        dec_in2 = in_imm;
      end
      OPC_AUIPC: begin
        dec_in1 = in_pc;
        dec_in2 = in_imm;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM: next state. Illegal instructions also pass through EXEC, so every
  // instruction takes the same number of cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: if (in_valid) begin
        state_next = S_EXEC;
        cnt_next   = CNT_W'(ALU_LAT);
      end
      S_EXEC: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1))
          state_next = S_RESP;
      end
      S_RESP: if (wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_reg == S_IDLE);
    wb_valid = (state_reg == S_RESP);
  end

  // Datapath registers. They load only on accept or capture, so everything
  // stays stable while a result waits for writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_reg     <= '0;
      alu_in1_reg    <= '0;
      alu_in2_reg    <= '0;
      rd_reg         <= '0;
      ill_reg        <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      wb_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        alu_op_reg  <= dec_op;
        alu_in1_reg <= dec_in1;
        alu_in2_reg <= dec_in2;
        rd_reg      <= in_rd;
        ill_reg     <= dec_illegal;
      end
      if (capture) begin
        wb_data_reg    <= ill_reg ? '0 : alu_out;
        wb_rd_reg      <= rd_reg;
        wb_illegal_reg <= ill_reg;
      end
    end
  end

  assign alu_op     = alu_op_reg;
  assign alu_in1    = alu_in1_reg;
  assign alu_in2    = alu_in2_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_data    = wb_data_reg;
  assign wb_illegal = wb_illegal_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

  localparam int XLEN = 32;
  localparam int LAT  = 1;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic        ill;
    logic [4:0]  op;
    logic [31:0] in1, in2, data;
  } exp_t;

  typedef struct {
    string  name;
    instr_t i;
    exp_t   e;
    int     hold;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [6:0]      in_opcode, in_funct7;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]      in_rd;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
  logic            wb_valid, wb_ready, wb_illegal;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  alu_dispatch #(.ALU_LAT(LAT), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
`ifdef ALU_DISPATCH_FWD_EN
    .in_rs1_idx(5'd0), .in_rs2_idx(5'd0),
`endif
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_illegal(wb_illegal)
  );

  // Stand-in ALU. With LAT=1 the dispatcher's operand registers are the only
  // stage, so the result is a combinational function of them.
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a << b[4:0];
      5'h03: return a ^ b;
      5'h04: return a >> b[4:0];
      5'h05: return $signed(a) >>> b[4:0];
      5'h06: return a | b;
      5'h07: return a & b;
      5'h08: return {31'b0, $signed(a) < $signed(b)};
      5'h09: return {31'b0, a < b};
      5'h10: return a * b;
      5'h11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      5'h12: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
      5'h13: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_model(alu_op, alu_in1, alu_in2);

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    cyc++;
  end

  // Reference: works from instruction semantics (mnemonic -> arithmetic).
  function automatic exp_t ref_model(input instr_t i);
    exp_t e;
    logic [31:0] a, b;
    logic [4:0]  sh;
    longint      sa, sb;
    longint unsigned ua, ub, pu;
    logic        imm_form, alt, base;
    e = '{ill: 1'b0, op: 5'h00, in1: '0, in2: '0, data: '0};
    a = i.rs1;
    imm_form = (i.opc == OPIMM);
    b = imm_form ? i.imm : i.rs2;
    sh = b[4:0];
    alt = (i.f7 == 7'b0100000);
    base = (i.f7 == 7'b0000000);
    if (i.opc == LUI) begin
      e.in2 = i.imm; e.data = i.imm;
    end else if (i.opc == AUIPC) begin
      e.in1 = i.pc; e.in2 = i.imm; e.data = i.pc + i.imm;
    end else if (i.opc == OP || imm_form) begin
      e.in1 = a; e.in2 = b;
      if (!imm_form && i.f7 == 7'b0000001) begin
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        case (i.f3)
          3'd0: begin e.op = 5'h10; e.data = a * b; end
          3'd1: begin e.op = 5'h11; pu = longint'(sa * sb); e.data = pu[63:32]; end
          3'd2: begin e.op = 5'h12; pu = longint'(sa * longint'(ub)); e.data = pu[63:32]; end
          3'd3: begin e.op = 5'h13; pu = ua * ub; e.data = pu[63:32]; end
          default: e.ill = 1'b1;
        endcase
      end else begin
        case (i.f3)
          3'd0: if (imm_form || base) begin e.op = 5'h00; e.data = a + b; end
                else if (alt) begin e.op = 5'h01; e.data = a - b; end
                else e.ill = 1'b1;
          3'd1: begin e.op = 5'h02; e.in2 = 32'(sh); e.data = a << sh; e.ill = !base; end
          3'd2: begin e.op = 5'h08; e.data = ($signed(a) < $signed(b)) ? 1 : 0; e.ill = !(imm_form || base); end
          3'd3: begin e.op = 5'h09; e.data = (a < b) ? 1 : 0; e.ill = !(imm_form || base); end
          3'd4: begin e.op = 5'h03; e.data = a ^ b; e.ill = !(imm_form || base); end
          3'd5: begin
            e.in2 = 32'(sh);
            if (base) begin e.op = 5'h04; e.data = a >> sh; end
            else if (alt) begin e.op = 5'h05; e.data = $signed(a) >>> sh; end
            else e.ill = 1'b1;
          end
          3'd6: begin e.op = 5'h06; e.data = a | b; e.ill = !(imm_form || base); end
          default: begin e.op = 5'h07; e.data = a & b; e.ill = !(imm_form || base); end
        endcase
      end
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e.data = '0;
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    instr_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc; i.rd = rd;
    return i;
  endfunction

  function automatic exp_t mke(input logic ill, input logic [4:0] op, input logic [31:0] in1,
                               input logic [31:0] in2, input logic [31:0] data);
    exp_t e;
    e.ill = ill; e.op = op; e.in1 = in1; e.in2 = in2; e.data = data;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: i.opc = OP;
      4, 5, 6:    i.opc = OPIMM;
      7:          i.opc = LUI;
      8:          i.opc = AUIPC;
      default:    i.opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       i.f7 = 7'b0000000;
      1:       i.f7 = 7'b0100000;
      2:       i.f7 = 7'b0000001;
      default: i.f7 = 7'($urandom);
    endcase
    i.f3 = 3'($urandom); i.rs1 = $urandom; i.rs2 = $urandom;
    i.imm = $urandom; i.pc = $urandom; i.rd = 5'($urandom);
    return i;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One instruction through the block. Entry and exit are at a negedge with
  // the block idle. hold = cycles wb_ready stays low once wb_valid is seen.
  task automatic run_txn(input string name, input instr_t ins, input exp_t e, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_opcode = ins.opc; in_funct3 = ins.f3; in_funct7 = ins.f7;
    in_rs1 = ins.rs1; in_rs2 = ins.rs2; in_imm = ins.imm; in_pc = ins.pc; in_rd = ins.rd;
    in_valid = 1'b1;
    wb_ready = (hold == 0);
    @(posedge clk); #1;
    // Scramble the inputs so that only registered values can produce the result.
    in_valid = 1'b0;
    in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom; in_pc = $urandom;
    in_rd = 5'($urandom); in_opcode = 7'($urandom);
    @(negedge clk);
    chk({name, ".busy"}, 32'(in_ready), 32'd0);
    if (!e.ill) begin
      chk({name, ".alu_op"}, 32'(alu_op), 32'(e.op));
      chk({name, ".alu_in1"}, alu_in1, e.in1);
      chk({name, ".alu_in2"}, alu_in2, e.in2);
    end
    n = 1;
    while (!wb_valid && n < LAT + 8) begin @(negedge clk); n++; end
    chk({name, ".latency"}, 32'(n), 32'(LAT + 1));
    chk({name, ".wb_data"}, wb_data, e.data);
    chk({name, ".wb_rd"}, 32'(wb_rd), 32'(ins.rd));
    chk({name, ".wb_illegal"}, 32'(wb_illegal), 32'(e.ill));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, ".hold_valid"}, 32'(wb_valid), 32'd1);
      chk({name, ".hold_data"}, wb_data, e.data);
      chk({name, ".hold_rd"}, 32'(wb_rd), 32'(ins.rd));
      chk({name, ".hold_ready"}, 32'(in_ready), 32'd0);
      if (!e.ill) chk({name, ".hold_op"}, 32'(alu_op), 32'(e.op));
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk({name, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({name, ".idle_valid"}, 32'(wb_valid), 32'd0);
    $display("txn %-10s opc=%b f3=%0d f7=%b rd=%0d data=%h ill=%0d", name, ins.opc, ins.f3,
             ins.f7, ins.rd, e.data, e.ill);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".wb_valid"}, 32'(wb_valid), 32'd0);
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({name, ".wb_data"}, wb_data, 32'd0);
    chk({name, ".wb_rd"}, 32'(wb_rd), 32'd0);
    chk({name, ".wb_illegal"}, 32'(wb_illegal), 32'd0);
    chk({name, ".alu_op"}, 32'(alu_op), 32'd0);
    chk({name, ".alu_in1"}, alu_in1, 32'd0);
    chk({name, ".alu_in2"}, alu_in2, 32'd0);
  endtask

  // Watch for a stale result for a few cycles after a reset.
  task automatic no_stale(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_valid) seen++;
    end
    chk({name, ".stale"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];

  initial begin
    instr_t ri;
    int n;
    tbl[0]  = '{"add",     mk(OP, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3),
                mke(0, 5'h00, 32'd5, 32'd7, 32'd12), 0};
    tbl[1]  = '{"sub",     mk(OP, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 32'd0, 5'd4),
                mke(0, 5'h01, 32'd3, 32'd5, 32'hFFFF_FFFE), 0};
    tbl[2]  = '{"srai",    mk(OPIMM, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_FFFF, 32'h404, 32'd0, 5'd5),
                mke(0, 5'h05, 32'h8000_0000, 32'd4, 32'hF800_0000), 0};
    tbl[3]  = '{"lui",     mk(LUI, 3'd0, 7'h00, 32'h0000_AAAA, 32'd1, 32'h1234_5000, 32'h40, 5'd6),
                mke(0, 5'h00, 32'd0, 32'h1234_5000, 32'h1234_5000), 0};
    tbl[4]  = '{"auipc",   mk(AUIPC, 3'd0, 7'h00, 32'd9, 32'd9, 32'h1000, 32'h100, 5'd7),
                mke(0, 5'h00, 32'h100, 32'h1000, 32'h1100), 0};
    tbl[5]  = '{"mulhu",   mk(OP, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd8),
                mke(0, 5'h13, 32'hFFFF_FFFF, 32'd2, 32'd1), 0};
    tbl[6]  = '{"ill_div", mk(OP, 3'd4, 7'h01, 32'd100, 32'd7, 32'd0, 32'd0, 5'd9),
                mke(1, 5'h00, 32'd0, 32'd0, 32'd0), 0};
    tbl[7]  = '{"xor_hold", mk(OP, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 5'd10),
                mke(0, 5'h03, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00), 5};
    tbl[8]  = '{"sll_reg", mk(OP, 3'd1, 7'h00, 32'd1, 32'h0000_0023, 32'd0, 32'd0, 5'd11),
                mke(0, 5'h02, 32'd1, 32'd3, 32'd8), 0};
    tbl[9]  = '{"ill_sll", mk(OP, 3'd1, 7'h20, 32'd1, 32'd2, 32'd0, 32'd0, 5'd12),
                mke(1, 5'h00, 32'd0, 32'd0, 32'd0), 0};
    tbl[10] = '{"slti",    mk(OPIMM, 3'd2, 7'h7F, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd13),
                mke(0, 5'h08, 32'hFFFF_FFFF, 32'd0, 32'd1), 0};
    tbl[11] = '{"add_x0",  mk(OP, 3'd0, 7'h00, 32'd20, 32'd22, 32'd0, 32'd0, 5'd0),
                mke(0, 5'h00, 32'd20, 32'd22, 32'd42), 2};

    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rd = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("por_rel");

    for (int k = 0; k < 12; k++)
      run_txn(tbl[k].name, tbl[k].i, tbl[k].e, tbl[k].hold);

    // Back-to-back throughput with in_valid and wb_ready held high.
    acc_q.delete();
    in_opcode = OP; in_funct3 = 3'd0; in_funct7 = 7'h00;
    in_rs1 = 32'd1; in_rs2 = 32'd2; in_rd = 5'd1;
    in_valid = 1'b1; wb_ready = 1'b1;
    n = 0;
    while (acc_q.size() < 3 && n < 40) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    chk("thru.accepts", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 3) begin
      chk("thru.gap1", 32'(acc_q[1] - acc_q[0]), 32'(LAT + 2));
      chk("thru.gap2", 32'(acc_q[2] - acc_q[1]), 32'(LAT + 2));
    end
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    $display("txn thru      accepts=%0d", acc_q.size());

    // Reset while in EXEC.
    in_opcode = OP; in_funct3 = 3'd0; in_funct7 = 7'h00;
    in_rs1 = 32'd100; in_rs2 = 32'd200; in_rd = 5'd17;
    in_valid = 1'b1; wb_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("rst_exec");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec.rel_ready", 32'(in_ready), 32'd1);
    no_stale("rst_exec");
    $display("txn rst_exec  done");

    // Reset while a result waits in RESP.
    in_rs1 = 32'd5; in_rs2 = 32'd6; in_rd = 5'd18;
    in_valid = 1'b1; wb_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 20) begin @(negedge clk); n++; end
    chk("rst_resp.reached", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("rst_resp");
    rst = 1'b0;
    wb_ready = 1'b1;
    no_stale("rst_resp");
    $display("txn rst_resp  done");

    for (int k = 0; k < 200; k++) begin
      ri = rand_instr();
      run_txn($sformatf("rnd%0d", k), ri, ref_model(ri), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
